// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg
//  Shared definitions for the run/halt/step sequencer.
//  The `define block carries the 3-bit state width and the state codes as
//  plain macros so the MMIO status register block can decode the state
//  output without importing this package. The enum below is built from the
//  same macros, so the two views cannot drift apart.
//  Optional feature macro (used by cpu_run_ctrl): CPU_RUN_CTRL_BKPT_EN.
`ifndef CPU_RUN_CTRL_DEFS_SV
`define CPU_RUN_CTRL_DEFS_SV
`define CPU_RUN_CTRL_STATE_W     3
`define CPU_RUN_CTRL_ST_RSTHOLD  3'd0
`define CPU_RUN_CTRL_ST_HALT     3'd1
`define CPU_RUN_CTRL_ST_RUN      3'd2
`define CPU_RUN_CTRL_ST_STEP     3'd3
`define CPU_RUN_CTRL_ST_BURST    3'd4
`define CPU_RUN_CTRL_ST_REPEAT   3'd5
`endif

package cpu_run_ctrl_pkg;

  localparam int STATE_W = `CPU_RUN_CTRL_STATE_W;
  localparam int TIMER_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_RSTHOLD = `CPU_RUN_CTRL_ST_RSTHOLD,
    ST_HALT    = `CPU_RUN_CTRL_ST_HALT,
    ST_RUN     = `CPU_RUN_CTRL_ST_RUN,
    ST_STEP    = `CPU_RUN_CTRL_ST_STEP,
    ST_BURST   = `CPU_RUN_CTRL_ST_BURST,
    ST_REPEAT  = `CPU_RUN_CTRL_ST_REPEAT
  } run_state_t;

  // The timer flags zero after load_val+1 observed cycles, so an interval of
  // N cycles is loaded as N-1.
  function automatic logic [TIMER_W-1:0] timer_reload(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
//  Bundles the button-side request signals, the core-side observation
//  signals and the sequencer outputs into one port.
//  master modport: the side that drives the requests (button stage / core).
//  slave modport : the sequencer itself.
//  Signals:
//    run_pulse, step_pulse, burst_pulse  1-cycle request pulses
//    step_level                          held level of the step button
//    burst_len[15:0]                     burst length, sampled on acceptance
//    pc[31:0], bkpt_addr[31:0], bkpt_valid  breakpoint compare inputs
//    cpu_ce, cpu_rst_n                   core clock-enable and reset
//    state[2:0], halted, bkpt_hit, ce_count[31:0]  status
interface cpu_run_ctrl_if;

  logic        run_pulse;
  logic        step_pulse;
  logic        step_level;
  logic        burst_pulse;
  logic [15:0] burst_len;
  logic [31:0] pc;
  logic [31:0] bkpt_addr;
  logic        bkpt_valid;

  logic        cpu_ce;
  logic        cpu_rst_n;
  logic [2:0]  state;
  logic        halted;
  logic        bkpt_hit;
  logic [31:0] ce_count;

  modport master (
    output run_pulse, step_pulse, step_level, burst_pulse, burst_len,
    output pc, bkpt_addr, bkpt_valid,
    input  cpu_ce, cpu_rst_n, state, halted, bkpt_hit, ce_count
  );

  modport slave (
    input  run_pulse, step_pulse, step_level, burst_pulse, burst_len,
    input  pc, bkpt_addr, bkpt_valid,
    output cpu_ce, cpu_rst_n, state, halted, bkpt_hit, ce_count
  );

endinterface

// File: rtl/cpu_run_ctrl_timer.sv
// run_ctrl_timer
//  Loadable down-counter with a zero flag. Counts down by one per cycle while
//  dec is high and parks at zero. load takes priority over dec.
//  Ports:
//    clk, rst_n       clock, asynchronous active-low reset (count <= INIT)
//    load, load_val   synchronous load
//    dec              decrement enable
//    zero             count == 0
module run_ctrl_timer #(
  parameter int           W    = 32,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= INIT;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//  Run/halt/step sequencer for the rv32i core. Holds the core in reset after
//  power-up, then gates the core clock-enable in free-run, single-step,
//  N-cycle burst or auto-repeat step mode.
//  Ports:
//    clk    system clock
//    rst_n  asynchronous active-low reset
//    bus    cpu_run_ctrl_if.slave (requests in, cpu_ce/cpu_rst_n/status out)
//  Optional feature: define CPU_RUN_CTRL_BKPT_EN to enable the PC breakpoint
//  stop. Without it pc/bkpt_addr/bkpt_valid are ignored and bkpt_hit is 0.
//  One shared timer serves the reset hold, the step-hold detector and the
//  repeat interval; only one of these is ever active in a given state.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int RST_HOLD   = 16,
  parameter int HOLD_CYC   = 2**24,
  parameter int REPEAT_CYC = 2**22,
  parameter bit START_RUN  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_run_ctrl_if.slave bus
);

  localparam logic [TIMER_W-1:0] RST_LOAD  = timer_reload(RST_HOLD);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = timer_reload(HOLD_CYC);
  localparam logic [TIMER_W-1:0] REP_LOAD  = timer_reload(REPEAT_CYC);

  run_state_t   state_reg;
  logic         ce_reg;
  logic         cpu_rst_n_reg;
  logic         halted_reg;
  logic         hit_reg;
  logic         skip_reg;       // first ce cycle after leaving HALT
  logic [15:0]  burst_cnt_reg;  // remaining burst cycles after the current one
  logic [31:0]  ce_count_reg;

  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;
  logic [TIMER_W-1:0]  tmr_val;
  logic                burst_ok;
  logic                accept;
  logic                bkpt_stop;

  assign burst_ok = bus.burst_pulse && (bus.burst_len != 16'd0);
  assign accept   = bus.run_pulse || burst_ok || bus.step_pulse;

`ifdef CPU_RUN_CTRL_BKPT_EN
  // Suppressed on the first ce cycle so execution can leave a breakpoint.
  assign bkpt_stop    = ce_reg && !skip_reg && bus.bkpt_valid && (bus.pc == bus.bkpt_addr);
  assign bus.bkpt_hit = hit_reg;
`else
  logic unused_bkpt;
  assign unused_bkpt  = ^{bus.pc, bus.bkpt_addr, bus.bkpt_valid, hit_reg, skip_reg};
  assign bkpt_stop    = 1'b0;
  assign bus.bkpt_hit = 1'b0;
`endif

  run_ctrl_timer #(
    .W    (TIMER_W),
    .INIT (RST_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Timer sequencing. Outside HALT/REPEAT/RSTHOLD the timer is kept primed
  // with the hold interval, so every entry into HALT starts a fresh
  // consecutive-hold count.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = HOLD_LOAD;
    case (state_reg)
      ST_RSTHOLD: begin
        if (tmr_zero) tmr_load = 1'b1;
        else          tmr_dec  = 1'b1;
      end
      ST_HALT: begin
        if (accept || !bus.step_level) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = REP_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (bus.run_pulse || bkpt_stop || !bus.step_level) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = REP_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: tmr_load = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RSTHOLD;
      ce_reg        <= 1'b0;
      cpu_rst_n_reg <= 1'b0;
      halted_reg    <= 1'b0;
      hit_reg       <= 1'b0;
      skip_reg      <= 1'b0;
      burst_cnt_reg <= 16'd0;
      ce_count_reg  <= 32'd0;
    end else begin
      ce_count_reg <= ce_count_reg + {31'd0, ce_reg};
      if (ce_reg) skip_reg <= 1'b0;

      case (state_reg)
        ST_RSTHOLD: begin
          if (tmr_zero) begin
            cpu_rst_n_reg <= 1'b1;
            if (START_RUN) begin
              state_reg <= ST_RUN;
              ce_reg    <= 1'b1;
              skip_reg  <= 1'b1;
            end else begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end
          end
        end

        ST_HALT: begin
          ce_reg <= 1'b0;
          if (accept || (bus.step_level && tmr_zero)) begin
            ce_reg     <= 1'b1;
            halted_reg <= 1'b0;
            skip_reg   <= 1'b1;
            if (accept) hit_reg <= 1'b0;
            if (bus.run_pulse) begin
              state_reg <= ST_RUN;
            end else if (burst_ok) begin
              state_reg     <= ST_BURST;
              burst_cnt_reg <= bus.burst_len - 16'd1;
            end else if (bus.step_pulse) begin
              state_reg <= ST_STEP;
            end else begin
              state_reg <= ST_REPEAT;
            end
          end
        end

        ST_STEP: begin
          state_reg  <= ST_HALT;
          ce_reg     <= 1'b0;
          halted_reg <= 1'b1;
        end

        ST_RUN: begin
          if (bkpt_stop || bus.run_pulse) begin
            state_reg  <= ST_HALT;
            ce_reg     <= 1'b0;
            halted_reg <= 1'b1;
            if (bkpt_stop) hit_reg <= 1'b1;
          end
        end

        ST_BURST: begin
          if (bkpt_stop || bus.run_pulse || (burst_cnt_reg == 16'd0)) begin
            state_reg  <= ST_HALT;
            ce_reg     <= 1'b0;
            halted_reg <= 1'b1;
            if (bkpt_stop) hit_reg <= 1'b1;
          end else begin
            burst_cnt_reg <= burst_cnt_reg - 16'd1;
          end
        end

        ST_REPEAT: begin
          if (bkpt_stop || !bus.step_level) begin
            state_reg  <= ST_HALT;
            ce_reg     <= 1'b0;
            halted_reg <= 1'b1;
            if (bkpt_stop) hit_reg <= 1'b1;
          end else if (bus.run_pulse) begin
            state_reg <= ST_RUN;
            ce_reg    <= 1'b1;
            hit_reg   <= 1'b0;
          end else begin
            ce_reg <= tmr_zero;
          end
        end

        default: begin
          state_reg  <= ST_HALT;
          ce_reg     <= 1'b0;
          halted_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_ce    = ce_reg;
  assign bus.cpu_rst_n = cpu_rst_n_reg;
  assign bus.state     = state_reg;
  assign bus.halted    = halted_reg;
  assign bus.ce_count  = ce_count_reg;

endmodule
